div_16_seq: RTL and testbench

- Multi-cycle restoring integer divider for the ALU datapath, the inverse of the adder/multiplier path.
- Each iteration does one trial subtraction: divisor inverted, added with carry-in 1.
- Started by a one-cycle `ctrl_div` pulse; returns quotient, remainder, a one-cycle ready strobe, and an exception flag for divide-by-zero and signed overflow.

---
 rtl/div_16_seq_if.sv | 23 ++
 rtl/div_16_seq.sv | 156 +++++++++++++++
 tb/tb_div_16_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/div_16_seq_if.sv
// Handshake/result bundle for the sequential divider; master = requester, slave = divider.
interface div_16_seq_if #(
   parameter int WIDTH = 16
);
   logic             ctrl_div;
   logic [WIDTH-1:0] operand0;
   logic [WIDTH-1:0] operand1;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             result_rdy;
   logic             exception;
   logic             busy;

   modport master (
      output ctrl_div, operand0, operand1,
      input  quotient, remainder, result_rdy, exception, busy
   );

   modport slave (
      input  ctrl_div, operand0, operand1,
      output quotient, remainder, result_rdy, exception, busy
   );
endinterface

// File: rtl/div_16_seq.sv
// Restoring divider, one quotient bit per cycle; result_rdy WIDTH+2 cycles after the start edge, new start taken in IDLE or DONE.
// DIV_SIGNED_EN selects two's-complement operands with an overflow exception; otherwise the divide is unsigned.
module div_16_seq #(
   parameter int WIDTH = 16
) (
   input  logic        i_clock,
   input  logic        i_reset,
   div_16_seq_if.slave io_bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, SETUP, ITER, FIX, DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] r_op0;
   logic [WIDTH-1:0] r_op1;
   logic [WIDTH-1:0] r_dividend;
   logic [WIDTH-1:0] r_divisor;
   logic [WIDTH:0]   r_partial;
   logic [CW-1:0]    r_cnt;
   logic             r_q_neg;
   logic             r_r_neg;
   logic             r_ovf;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_exception;

   logic             w_start;
   logic             w_div_zero;
   logic             w_last;
   logic             w_sign0;
   logic             w_sign1;
   logic             w_ovf;
   logic [WIDTH-1:0] w_abs0;
   logic [WIDTH-1:0] w_abs1;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH+1:0] w_trial;
   logic             w_carry;
   logic [WIDTH-1:0] w_q_fix;
   logic [WIDTH-1:0] w_r_fix;
   logic             w_unused_pbit;

   assign w_start    = io_bus.ctrl_div && (r_state == IDLE || r_state == DONE);
   assign w_div_zero = (io_bus.operand1 == '0);
   assign w_last     = (r_cnt == CW'(WIDTH - 1));

`ifdef DIV_SIGNED_EN
   assign w_sign0 = r_op0[WIDTH-1];
   assign w_sign1 = r_op1[WIDTH-1];
   assign w_ovf   = (r_op0 == MOST_NEG) && (&r_op1);
`else
   assign w_sign0 = 1'b0;
   assign w_sign1 = 1'b0;
   assign w_ovf   = 1'b0;
`endif

   // |MOST_NEG| stays MOST_NEG, which is exactly right read as unsigned magnitude
   assign w_abs0 = w_sign0 ? -r_op0 : r_op0;
   assign w_abs1 = w_sign1 ? -r_op1 : r_op1;

   assign w_shift = {r_partial[WIDTH-1:0], r_dividend[WIDTH-1]};
   assign w_trial = {1'b0, w_shift} + {1'b0, ~{1'b0, r_divisor}} + {{(WIDTH+1){1'b0}}, 1'b1};
   assign w_carry = w_trial[WIDTH+1];

   // Kept remainder is always below the divisor, so its top bit never feeds the next shift
   assign w_unused_pbit = r_partial[WIDTH];

   assign w_q_fix = r_q_neg ? -r_dividend : r_dividend;
   assign w_r_fix = r_r_neg ? -r_partial[WIDTH-1:0] : r_partial[WIDTH-1:0];

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE, DONE: begin
            if (w_start) begin
               w_state_nxt = w_div_zero ? DONE : SETUP;
            end else if (r_state == DONE) begin
               w_state_nxt = IDLE;
            end
         end
         SETUP:   w_state_nxt = ITER;
         ITER:    w_state_nxt = w_last ? FIX : ITER;
         FIX:     w_state_nxt = DONE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_op0       <= '0;
         r_op1       <= '0;
         r_dividend  <= '0;
         r_divisor   <= '0;
         r_partial   <= '0;
         r_cnt       <= '0;
         r_q_neg     <= 1'b0;
         r_r_neg     <= 1'b0;
         r_ovf       <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_exception <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (w_start) begin
                  r_op0       <= io_bus.operand0;
                  r_op1       <= io_bus.operand1;
                  r_exception <= w_div_zero;
                  if (w_div_zero) begin
                     r_quotient  <= '0;
                     r_remainder <= io_bus.operand0;
                  end
               end
            end
            SETUP: begin
               r_dividend <= w_abs0;
               r_divisor  <= w_abs1;
               r_partial  <= '0;
               r_cnt      <= '0;
               r_q_neg    <= w_sign0 ^ w_sign1;
               r_r_neg    <= w_sign0;
               r_ovf      <= w_ovf;
            end
            ITER: begin
               // Quotient bits shift into the vacated low end of the dividend register
               r_partial  <= w_carry ? w_trial[WIDTH:0] : w_shift;
               r_dividend <= {r_dividend[WIDTH-2:0], w_carry};
               r_cnt      <= r_cnt + CW'(1);
            end
            FIX: begin
               r_quotient  <= w_q_fix;
               r_remainder <= w_r_fix;
               r_exception <= r_ovf;
            end
            default: ;
         endcase
      end
   end

   assign io_bus.quotient   = r_quotient;
   assign io_bus.remainder  = r_remainder;
   assign io_bus.exception  = r_exception;
   assign io_bus.result_rdy = (r_state == DONE);
   assign io_bus.busy       = (r_state != IDLE);
endmodule

// File: tb/tb_div_16_seq.sv
// Directed bench for div_16_seq; expectations follow DIV_SIGNED_EN when it is defined.
module tb_div_16_seq;
   localparam int WIDTH = 16;

`ifdef DIV_SIGNED_EN
   localparam logic [15:0] Q_NEG100 = 16'hFFF2;
   localparam logic [15:0] R_NEG100 = 16'hFFFE;
   localparam logic [15:0] Q_OVF    = 16'h8000;
   localparam logic [15:0] R_OVF    = 16'h0000;
   localparam logic        E_OVF    = 1'b1;
   localparam logic [15:0] Q_FFFF2  = 16'h0000;
   localparam logic [15:0] R_FFFF2  = 16'hFFFF;
`else
   localparam logic [15:0] Q_NEG100 = 16'h2484;
   localparam logic [15:0] R_NEG100 = 16'h0000;
   localparam logic [15:0] Q_OVF    = 16'h0000;
   localparam logic [15:0] R_OVF    = 16'h8000;
   localparam logic        E_OVF    = 1'b0;
   localparam logic [15:0] Q_FFFF2  = 16'h7FFF;
   localparam logic [15:0] R_FFFF2  = 16'h0001;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_rdy;

   div_16_seq_if #(.WIDTH(WIDTH)) bus ();

   div_16_seq #(.WIDTH(WIDTH)) u_dut (
      .i_clock (clk),
      .i_reset (rst),
      .io_bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called just after a negedge; returns at the negedge where result_rdy is seen high.
   // elat = edges after the start edge at which the strobe cycle begins.
   task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input int repulse, input logic [15:0] eq, input logic [15:0] er,
                          input logic ee, input int elat);
      int lat;
      bit got;
      bus.ctrl_div = 1'b1;
      bus.operand0 = a;
      bus.operand1 = b;
      @(posedge clk);
      #1 bus.ctrl_div = 1'b0;
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (i == 0) check({tag, "_busy"}, 32'(bus.busy), 32'd1);
         if (bus.result_rdy) begin
            got = 1'b1;
         end else begin
            if (repulse > 0 && lat == repulse - 1) begin
               bus.ctrl_div = 1'b1;
               bus.operand0 = 16'd1;
               bus.operand1 = 16'd1;
            end else begin
               bus.ctrl_div = 1'b0;
            end
            @(posedge clk);
            lat++;
         end
      end
      check({tag, "_rdy"}, 32'(got), 32'd1);
      check({tag, "_lat"}, 32'(lat), 32'(elat));
      check({tag, "_q"}, 32'(bus.quotient), 32'(eq));
      check({tag, "_r"}, 32'(bus.remainder), 32'(er));
      check({tag, "_exc"}, 32'(bus.exception), 32'(ee));
   endtask

   task automatic count_rdy(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (bus.result_rdy) n++;
      end
   endtask

   initial begin
      rst          = 1'b1;
      bus.ctrl_div = 1'b0;
      bus.operand0 = '0;
      bus.operand1 = '0;
      repeat (3) @(negedge clk);
      check("rst_q", 32'(bus.quotient), 32'd0);
      check("rst_r", 32'(bus.remainder), 32'd0);
      check("rst_rdy", 32'(bus.result_rdy), 32'd0);
      check("rst_exc", 32'(bus.exception), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_div("d100_7", 16'd100, 16'd7, 0, 16'd14, 16'd2, 1'b0, 18);
      // Started during the result_rdy cycle of the previous divide
      run_div("b2b_20_6", 16'd20, 16'd6, 0, 16'd3, 16'd2, 1'b0, 18);
      @(negedge clk);
      check("b2b_busy_after", 32'(bus.busy), 32'd0);

      run_div("neg100_7", 16'hFF9C, 16'd7, 0, Q_NEG100, R_NEG100, 1'b0, 18);
      @(negedge clk);

      // Zero divisor goes straight to DONE on the start edge
      run_div("d5_0", 16'd5, 16'd0, 0, 16'd0, 16'd5, 1'b1, 0);
      @(negedge clk);
      check("d5_0_busy_after", 32'(bus.busy), 32'd0);
      check("d5_0_exc_held", 32'(bus.exception), 32'd1);

      run_div("ovf", 16'h8000, 16'hFFFF, 0, Q_OVF, R_OVF, E_OVF, 18);
      @(negedge clk);

      bus.ctrl_div = 1'b1;
      bus.operand0 = 16'd1000;
      bus.operand1 = 16'd3;
      @(posedge clk);
      #1 bus.ctrl_div = 1'b0;
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort_q", 32'(bus.quotient), 32'd0);
      check("abort_r", 32'(bus.remainder), 32'd0);
      check("abort_rdy", 32'(bus.result_rdy), 32'd0);
      check("abort_exc", 32'(bus.exception), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      count_rdy(30, n_rdy);
      check("abort_no_rdy", 32'(n_rdy), 32'd0);

      run_div("d9_3", 16'd9, 16'd3, 0, 16'd3, 16'd0, 1'b0, 18);
      @(negedge clk);

      run_div("repulse", 16'hFFFF, 16'd2, 5, Q_FFFF2, R_FFFF2, 1'b0, 18);
      count_rdy(30, n_rdy);
      check("repulse_one_rdy", 32'(n_rdy), 32'd0);
      check("repulse_q_held", 32'(bus.quotient), 32'(Q_FFFF2));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
